// File: rtl/i2s_pkg.sv
// Shared I2S definitions: default word/slot geometry, receiver state encoding
// and the data-window helper used by the slave.
package i2s_pkg;

   localparam int I2S_DATA_W = 24;
   localparam int I2S_SLOT_W = 32;

   typedef enum logic [1:0] {
      ST_HUNT  = 2'd0,
      ST_LEFT  = 2'd1,
      ST_RIGHT = 2'd2
   } i2s_state_e;

   // Rise index 0 is the WS-change rise; data occupies indices 1..data_w.
   function automatic logic in_data_window(input int idx, input int data_w);
      return (idx >= 32'sd1) && (idx <= data_w);
   endfunction

endpackage

// File: rtl/i2s_edge_det.sv
// Synchronises bclk/lrclk/din into the system clock domain and produces
// one-clock bclk rise/fall strobes with lrclk/din aligned to them.
module i2s_edge_det #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic bclk,
   input  logic lrclk,
   input  logic din,
   output logic rise,
   output logic fall,
   output logic lrclk_sync,
   output logic din_sync
);
   logic [SYNC_STAGES-1:0] bclk_sync_r;
   logic [SYNC_STAGES-1:0] lrclk_sync_r;
   logic [SYNC_STAGES-1:0] din_sync_r;
   logic                   bclk_prev_r;

   // equal-depth synchroniser chains plus one extra bclk sample for edge detection
   always_ff @(posedge clock) begin
      if (reset) begin
         bclk_sync_r  <= '0;
         lrclk_sync_r <= '0;
         din_sync_r   <= '0;
         bclk_prev_r  <= 1'b0;
      end else begin
         bclk_sync_r[0]  <= bclk;
         lrclk_sync_r[0] <= lrclk;
         din_sync_r[0]   <= din;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            bclk_sync_r[i]  <= bclk_sync_r[i-1];
            lrclk_sync_r[i] <= lrclk_sync_r[i-1];
            din_sync_r[i]   <= din_sync_r[i-1];
         end
         bclk_prev_r <= bclk_sync_r[SYNC_STAGES-1];
      end
   end

   assign rise       = bclk_sync_r[SYNC_STAGES-1] & ~bclk_prev_r;
   assign fall       = ~bclk_sync_r[SYNC_STAGES-1] & bclk_prev_r;
   assign lrclk_sync = lrclk_sync_r[SYNC_STAGES-1];
   assign din_sync   = din_sync_r[SYNC_STAGES-1];

endmodule

// File: rtl/i2s_ext_slave.sv
// I2S slave running entirely on the system clock: frames received words on
// lrclk changes and serialises the transmit words on bclk falls.
module i2s_ext_slave
   import i2s_pkg::*;
#(
   parameter int DATA_W      = I2S_DATA_W,
   parameter int SLOT_W      = I2S_SLOT_W,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              bclk,
   input  logic              lrclk,
   input  logic              din,
   output logic              dout,
   output logic [DATA_W-1:0] rx_left,
   output logic [DATA_W-1:0] rx_right,
   output logic              rx_valid,
   input  logic [DATA_W-1:0] tx_left,
   input  logic [DATA_W-1:0] tx_right,
   output logic              tx_load,
   output logic              locked,
   output logic              frame_err
);
   localparam int               CNT_W   = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SLOT_W - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic              rise_s;
   logic              fall_s;
   logic              ws_s;
   logic              din_s;
   logic              ws_change_s;
   logic              slot_full_s;
   logic              slot_err_s;
   logic              frame_ok_s;
   logic              data_bit_s;
   logic [CNT_W-1:0]  idx_s;
   i2s_state_e        state_r;
   i2s_state_e        state_nxt_s;

   logic              ws_prev_r;
   logic              left_ok_r;
   logic              locked_r;
   logic              rx_valid_r;
   logic              frame_err_r;
   logic              tx_load_r;
   logic              dout_r;
   logic [CNT_W-1:0]  bit_cnt_r;
   logic [DATA_W-1:0] rx_sh_r;
   logic [DATA_W-1:0] left_word_r;
   logic [DATA_W-1:0] rx_left_r;
   logic [DATA_W-1:0] rx_right_r;
   logic [DATA_W-1:0] tx_sh_r;
   logic [DATA_W-1:0] tx_right_hold_r;

   i2s_edge_det #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_edge_det (
      .clock      (clock),
      .reset      (reset),
      .bclk       (bclk),
      .lrclk      (lrclk),
      .din        (din),
      .rise       (rise_s),
      .fall       (fall_s),
      .lrclk_sync (ws_s),
      .din_sync   (din_s)
   );

   // rise-time decode: WS change, position of this rise in the slot, data window
   always_comb begin
      ws_change_s = 1'b0;
      idx_s       = bit_cnt_r;
      data_bit_s  = 1'b0;
      slot_full_s = (bit_cnt_r == CNT_MAX);
      if (rise_s) begin
         ws_change_s = (ws_s != ws_prev_r);
         if (ws_change_s) begin
            idx_s = '0;
         end else if (slot_full_s) begin
            idx_s = CNT_MAX;
         end else begin
            idx_s = bit_cnt_r + CNT_ONE;
         end
         data_bit_s = !ws_change_s && in_data_window(int'(idx_s), DATA_W);
      end else begin
         ws_change_s = 1'b0;
      end
   end

   // state register
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r <= ST_HUNT;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // next state and slot-length judgement on each WS change
   always_comb begin
      state_nxt_s = state_r;
      slot_err_s  = 1'b0;
      frame_ok_s  = 1'b0;
      if (ws_change_s) begin
         case (state_r)
            ST_HUNT: begin
               if (!ws_s) begin
                  state_nxt_s = ST_LEFT;
               end else begin
                  state_nxt_s = ST_HUNT;
               end
            end
            ST_LEFT, ST_RIGHT: begin
               slot_err_s = !slot_full_s;
               if (ws_s) begin
                  state_nxt_s = ST_RIGHT;
               end else begin
                  state_nxt_s = ST_LEFT;
               end
               frame_ok_s = (state_r == ST_RIGHT) && !ws_s && slot_full_s && left_ok_r;
            end
            default: begin
               state_nxt_s = ST_HUNT;
            end
         endcase
      end else begin
         state_nxt_s = state_r;
      end
   end

   // slot counter, receive shifter, lock tracking and receive outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         ws_prev_r   <= 1'b0;
         bit_cnt_r   <= '0;
         rx_sh_r     <= '0;
         left_word_r <= '0;
         left_ok_r   <= 1'b0;
         locked_r    <= 1'b0;
         rx_left_r   <= '0;
         rx_right_r  <= '0;
         rx_valid_r  <= 1'b0;
         frame_err_r <= 1'b0;
      end else begin
         rx_valid_r  <= 1'b0;
         frame_err_r <= 1'b0;
         if (rise_s) begin
            ws_prev_r <= ws_s;
            bit_cnt_r <= idx_s;
         end
         if (ws_change_s) begin
            rx_sh_r   <= '0;
            left_ok_r <= (state_r == ST_LEFT) && slot_full_s;
            if (state_r == ST_LEFT) begin
               left_word_r <= rx_sh_r;
            end
            if (slot_err_s) begin
               frame_err_r <= 1'b1;
               locked_r    <= 1'b0;
            end else if (frame_ok_s) begin
               // the frame that first achieves lock is not itself published
               locked_r <= 1'b1;
               if (locked_r) begin
                  rx_left_r  <= left_word_r;
                  rx_right_r <= rx_sh_r;
                  rx_valid_r <= 1'b1;
               end
            end
         end else if (data_bit_s) begin
            rx_sh_r <= {rx_sh_r[DATA_W-2:0], din_s};
         end
      end
   end

   // transmit word capture on WS changes, serialisation on bclk falls
   always_ff @(posedge clock) begin
      if (reset) begin
         tx_sh_r         <= '0;
         tx_right_hold_r <= '0;
         tx_load_r       <= 1'b0;
         dout_r          <= 1'b0;
      end else begin
         tx_load_r <= 1'b0;
         if (rise_s) begin
            if (ws_change_s && !ws_s) begin
               tx_sh_r         <= tx_left;
               tx_right_hold_r <= tx_right;
               tx_load_r       <= 1'b1;
            end else if (ws_change_s && (state_nxt_s == ST_RIGHT)) begin
               tx_sh_r <= tx_right_hold_r;
            end
         end else if (fall_s) begin
            // zero fill makes dout idle low once the LSB has gone out
            if (state_r == ST_HUNT) begin
               dout_r <= 1'b0;
            end else begin
               dout_r  <= tx_sh_r[DATA_W-1];
               tx_sh_r <= {tx_sh_r[DATA_W-2:0], 1'b0};
            end
         end
      end
   end

   assign dout      = dout_r;
   assign rx_left   = rx_left_r;
   assign rx_right  = rx_right_r;
   assign rx_valid  = rx_valid_r;
   assign tx_load   = tx_load_r;
   assign locked    = locked_r;
   assign frame_err = frame_err_r;

endmodule

// File: doc/i2s_ext_slave.md
I2S_EXT_SLAVE -- requirements
Module: i2s_ext_slave

Interface
REQ-001 SHALL have parameter DATA_W, default 24: audio word width per channel.
REQ-002 SHALL have parameter SLOT_W, default 32: BCLK periods per channel slot (frame = 2*SLOT_W).
REQ-003 SHALL have parameter SYNC_STAGES, default 2: synchroniser depth for bclk/lrclk/din.
REQ-004 SHALL have port: clock  in  1  system clock; the only clock; at least 8x bclk frequency.
REQ-005 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port: bclk  in  1  external bit clock, asynchronous to clock.
REQ-007 SHALL have port: lrclk  in  1  external word select (0 = left, 1 = right), asynchronous.
REQ-008 SHALL have port: din  in  1  serial data from the external master.
REQ-009 SHALL have port: dout  out  1  serial data to the external master.
REQ-010 SHALL have port: rx_left, rx_right  out  DATA_W  last received frame, two's complement.
REQ-011 SHALL have port: rx_valid  out  1  one-clock pulse when rx_left/rx_right are updated.
REQ-012 SHALL have port: tx_left, tx_right  in  DATA_W  words for the next transmitted frame.
REQ-013 SHALL have port: tx_load  out  1  one-clock pulse when tx_left/tx_right are captured.
REQ-014 SHALL have port: locked  out  1  frame alignment is established.
REQ-015 SHALL have port: frame_err  out  1  one-clock pulse on a slot-length violation.

Function
REQ-016 SHALL pass bclk, lrclk and din through SYNC_STAGES flops, then detect bclk rise and fall as one-clock strobes from the last two synchronised bclk samples.
REQ-017 SHALL sample lrclk and din only on a bclk-rise strobe; a "WS change" is a rise whose lrclk sample differs from the previous rise's sample.
REQ-018 SHALL run states HUNT, LEFT, RIGHT: HUNT->LEFT on a 1->0 WS change; LEFT->RIGHT on a 0->1 change; RIGHT->LEFT on a 1->0 change; ignore 0->1 changes in HUNT.
REQ-019 SHALL clear bit_cnt to 0 on every WS change and increment it on every other rise, saturating at SLOT_W-1.
REQ-020 SHALL treat the rises at bit_cnt 1..DATA_W as data MSB..LSB (standard I2S one-bit delay) and ignore din on all other rises.
REQ-021 SHALL, on a WS change in LEFT/RIGHT with bit_cnt != SLOT_W-1, pulse frame_err, clear locked, discard the partial frame and continue in the state of the new slot.
REQ-022 SHALL set locked at the end of the first complete, error-free left+right frame.
REQ-023 SHALL, on a 1->0 WS change ending a complete right slot while locked, update rx_left/rx_right and pulse rx_valid in the clock after the rise strobe.
REQ-024 SHALL, on every 1->0 WS change (any state), capture tx_left/tx_right into the transmit shift register and pulse tx_load in the same clock as the capture.
REQ-025 SHALL drive dout on bclk-fall strobes: on the fall following the WS-change rise, drive the MSB of the current slot's word; on subsequent falls, drive the next bit; drive 0 after the LSB until the slot ends.
REQ-026 SHALL drive dout = 0 in HUNT.
REQ-027 SHALL ignore a simultaneous rise and fall strobe, which is impossible for a valid bclk, by giving the rise priority.

Reset
REQ-028 SHALL, while reset = 1 at a clock edge, set state = HUNT, bit_cnt = 0, dout = 0, rx_left = rx_right = 0, rx_valid = tx_load = frame_err = locked = 0, shift registers = 0 and synchroniser flops = 0.
REQ-029 SHALL abandon a frame in progress when reset is asserted, and SHALL require a fresh 1->0 WS change after reset before any capture or output.

Structure
REQ-030 SHALL place DATA_W/SLOT_W defaults and the HUNT/LEFT/RIGHT state encoding in shared package i2s_pkg.
REQ-031 SHALL implement synchronisation and edge detection as one sub-module i2s_edge_det, instantiated for bclk with lrclk/din delay-matched to it.

Verification
REQ-032 SHALL cover: 64-BCLK frames carrying left = 24'h123456 and right = 24'hABCDEF -> rx_left = 24'h123456, rx_right = 24'hABCDEF, rx_valid once per frame starting from the second frame, locked = 1.
REQ-033 SHALL cover: tx_left = 24'h800001, tx_right = 24'h7FFFFE, with master sampling dout on bclk rise -> master reads 24'h800001 / 24'h7FFFFE, 8 trailing zeros, tx_load once per frame.
REQ-034 SHALL cover: one slot shortened to 30 BCLK -> single frame_err pulse, locked = 0, no rx_valid for that frame, relock and valid data after the next full frame.
REQ-035 SHALL cover: reset asserted mid right slot -> all outputs 0 next clock, dout = 0 until a 1->0 WS change, correct data on the first full frame after it.
REQ-036 SHALL cover: start in lrclk = 1 (right slot) -> stays in HUNT, no rx_valid/tx_load until first 1->0 change.
REQ-037 SHALL cover: clock = 8x bclk with random bclk phase jitter of ±1 clock -> no frame_err over 1000 frames.
